pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It watches ID, EX and MEM stage status and drives the enable and flush inputs of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It handles load-use hazards, taken-branch redirects, a multi-cycle MULT/DIV unit, and a data-memory wait handshake with a watchdog timeout.

## Interface
- MUL_CYCLES, 4: busy cycles of MULT/MULTU; must be ≥1.
- DIV_CYCLES, 32: busy cycles of DIV/DIVU; must be ≥1.
- DM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before forced release; must be ≥1.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  the instruction in ID reads that source.
- ID_UsesHiLo  in  1  the instruction in ID is MFHI/MFLO/MTHI/MTLO/MULT/DIV.
- EX_Rw  in  5  destination register in EX.
- EX_RfWr  in  1  the instruction in EX writes the register file.
- EX_IsLoad  in  1  the instruction in EX is a load.
- EX_BranchTaken  in  1  branch or jump redirect resolved in EX.
- EX_MduStart  in  1  the instruction in EX starts the multiply/divide unit (MDU).
- EX_MduIsDiv  in  1  the started MDU op is a divide.
- MEM_DmReq  in  1  the instruction in MEM accesses data memory.
- DmAck  in  1  data memory completes the access this cycle.
- PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En  out  1 each  register load enables.
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble (RfWr=0, DmReq=0) instead of data; takes effect only when the matching _En is 1.
- MduBusy  out  1  the MDU state machine is in BUSY.
- MduDone  out  1  one-cycle pulse on the last busy cycle.
- DmErr  out  1  sticky flag: a data-memory watchdog timeout has occurred.

## Operation
- MDU FSM, states IDLE and BUSY:
  - In IDLE, a start is accepted when EX_MduStart=1 and EX_MEM_En=1. On accept, the counter loads (EX_MduIsDiv ? DIV_CYCLES : MUL_CYCLES)−1 and the FSM moves to BUSY.
  - In BUSY, the counter decrements each cycle. When the counter is 0: MduDone=1, and the FSM moves to IDLE.
  - A start with EX_MEM_En=0 is not accepted, so a frozen EX instruction cannot double-start.
  - Counter width is clog2(max(MUL_CYCLES, DIV_CYCLES)), minimum 1.
- Hazard terms (combinational):
  - loaduse = EX_IsLoad & EX_RfWr & (EX_Rw≠0) & ((ID_UsesRs & ID_Rs==EX_Rw) | (ID_UsesRt & ID_Rt==EX_Rw)).
  - mdustall = ID_UsesHiLo & (MduBusy | (EX_MduStart & state==IDLE)).
  - dmwait = MEM_DmReq & ~DmAck & ~timeout.
- Watchdog: the counter increments each cycle MEM_DmReq & ~DmAck holds, and clears otherwise. When it equals DM_TIMEOUT, timeout=1: freeze is released for that cycle, DmErr is set, and the counter clears.
- Output priority, highest first:
  1. freeze (dmwait): all _En=0 except MEM_WB_En=1 with MEM_WB_Flush=1. Flushes are suppressed, and any branch is held until freeze ends.
  2. branch (EX_BranchTaken): all _En=1; IF_ID_Flush=1 and ID_EX_Flush=1. Overrides loaduse and mdustall, because the stalled ID instruction is squashed.
  3. stall (loaduse | mdustall): PC_En=0, IF_ID_En=0, ID_EX_En=1 with ID_EX_Flush=1; EX_MEM_En=1 and MEM_WB_En=1.
  4. normal: all _En=1, all flushes 0.
- The MDU counter runs regardless of freeze.

## Timing
- While rst_n=0 at a clock edge: MDU→IDLE, counter=0, watchdog=0, DmErr=0.
- While rst_n=0, outputs are forced: all _En=0, all _Flush=1, MduBusy=0, MduDone=0.
- Reset mid-MDU-op aborts the op. The first cycle after release is IDLE/normal.
- Enables and flushes are combinational from inputs plus registered state, with zero-cycle latency.
- MDU start accepted in cycle t:
  - MduBusy=1 for cycles t+1 … t+N.
  - MduDone=1 in cycle t+N.
  - An ID_UsesHiLo instruction stalls in cycles t … t+N and advances at t+N+1.
- A zero-wait access (DmAck=1 in the same cycle as MEM_DmReq) causes no freeze.
- Maximum freeze is DM_TIMEOUT consecutive cycles. In the next cycle the pipeline advances and DmErr rises at the following edge.

## Test plan
- Load-use: EX lw $5, ID add $3,$5,$2 → one cycle with PC_En=0, IF_ID_En=0, ID_EX_Flush=1; next cycle all _En=1. Repeat with EX_Rw=0 → no stall.
- Branch plus load-use in the same cycle: EX_BranchTaken=1 with loaduse true → PC_En=1, IF_ID_Flush=1, ID_EX_Flush=1, no stall.
- DIV start then MFLO in ID → MduBusy high for exactly 32 cycles, MduDone at the 32nd, MFLO held 33 cycles. MULT gives 4 busy cycles and 5 held cycles.
- DM wait of 3 cycles (DmAck low 3, then high) → all _En=0 for 3 cycles with MEM_WB_Flush=1. An EX_BranchTaken asserted during the wait flushes only after the wait ends. EX_MduStart held during the wait → exactly one MDU op.
- DmAck never asserted with DM_TIMEOUT=16 → 16 freeze cycles, release in the 17th, DmErr=1 thereafter until rst_n=0.
- rst_n low mid-DIV (MduBusy=1) → after release MduBusy=0, DmErr=0, all _En=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline
// (load-use, branch redirect, multi-cycle MDU, data-memory wait watchdog).
module pipe_hazard_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int DM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_UsesRs,
   input  logic       ID_UsesRt,
   input  logic       ID_UsesHiLo,
   input  logic [4:0] EX_Rw,
   input  logic       EX_RfWr,
   input  logic       EX_IsLoad,
   input  logic       EX_BranchTaken,
   input  logic       EX_MduStart,
   input  logic       EX_MduIsDiv,
   input  logic       MEM_DmReq,
   input  logic       DmAck,
   output logic       PC_En,
   output logic       IF_ID_En,
   output logic       ID_EX_En,
   output logic       EX_MEM_En,
   output logic       MEM_WB_En,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Flush,
   output logic       MEM_WB_Flush,
   output logic       MduBusy,
   output logic       MduDone,
   output logic       DmErr
);
   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int WW = $clog2(DM_TIMEOUT + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [WW-1:0] wd;
   logic          err;
   logic          idle, busy, loaduse, mdustall, pend, timeout, dmwait, stall;

   always_comb begin
      idle     = state == IDLE;
      busy     = state == BUSY;
      loaduse  = EX_IsLoad & EX_RfWr & (EX_Rw != 5'd0) &
                 ((ID_UsesRs & (ID_Rs == EX_Rw)) | (ID_UsesRt & (ID_Rt == EX_Rw)));
      mdustall = ID_UsesHiLo & (busy | (EX_MduStart & idle));
      pend     = MEM_DmReq & ~DmAck;
      timeout  = wd == WW'(DM_TIMEOUT);
      dmwait   = pend & ~timeout;
      stall    = loaduse | mdustall;
      // a taken branch squashes the stalled ID instruction, so it wins over stall
      PC_En        = rst_n & ~dmwait & (EX_BranchTaken | ~stall);
      IF_ID_En     = PC_En;
      ID_EX_En     = rst_n & ~dmwait;
      EX_MEM_En    = rst_n & ~dmwait;
      MEM_WB_En    = rst_n;
      IF_ID_Flush  = ~rst_n | (~dmwait & EX_BranchTaken);
      ID_EX_Flush  = ~rst_n | (~dmwait & (EX_BranchTaken | stall));
      MEM_WB_Flush = ~rst_n | dmwait;
      MduBusy      = rst_n & busy;
      MduDone      = rst_n & busy & (cnt == '0);
      DmErr        = err;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         wd    <= '0;
         err   <= 1'b0;
      end else begin
         // gating on EX_MEM_En keeps a frozen EX instruction from starting twice
         if (idle & EX_MduStart & EX_MEM_En) begin
            state <= BUSY;
            cnt   <= EX_MduIsDiv ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
         end else if (busy) begin
            if (cnt == '0) state <= IDLE;
            else cnt <= cnt - 1'b1;
         end
         wd <= dmwait ? wd + 1'b1 : '0;
         if (timeout) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle sequences
// for the pipeline stall/flush sequencer.
module tb_pipe_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] ID_Rs, ID_Rt, EX_Rw;
   logic       ID_UsesRs, ID_UsesRt, ID_UsesHiLo, EX_RfWr, EX_IsLoad;
   logic       EX_BranchTaken, EX_MduStart, EX_MduIsDiv, MEM_DmReq, DmAck;
   logic       PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En;
   logic       IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, MduBusy, MduDone, DmErr;
   logic [7:0] outs;
   int         n_pass = 0, n_total = 0;

   // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, IF_ID,ID_EX,MEM_WB flushes}
   localparam logic [7:0] NORM = 8'b11111_000;
   localparam logic [7:0] STAL = 8'b00111_010;
   localparam logic [7:0] BRAN = 8'b11111_110;
   localparam logic [7:0] FRZ  = 8'b00001_001;
   localparam logic [7:0] RST  = 8'b00000_111;

   pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .DM_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_UsesHiLo(ID_UsesHiLo),
      .EX_Rw(EX_Rw), .EX_RfWr(EX_RfWr), .EX_IsLoad(EX_IsLoad),
      .EX_BranchTaken(EX_BranchTaken), .EX_MduStart(EX_MduStart),
      .EX_MduIsDiv(EX_MduIsDiv), .MEM_DmReq(MEM_DmReq), .DmAck(DmAck),
      .PC_En(PC_En), .IF_ID_En(IF_ID_En), .ID_EX_En(ID_EX_En),
      .EX_MEM_En(EX_MEM_En), .MEM_WB_En(MEM_WB_En), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .MEM_WB_Flush(MEM_WB_Flush),
      .MduBusy(MduBusy), .MduDone(MduDone), .DmErr(DmErr)
   );

   always #5 clk = ~clk;
   assign outs = {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
                  IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush};

   typedef struct {
      logic [4:0] rs, rt, rw;
      logic       urs, urt, uhl, rfwr, ld, br, dmreq, ack;
      logic [7:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, got, exp);
   endtask

   task automatic clr();
      {ID_Rs, ID_Rt, EX_Rw} = '0;
      {ID_UsesRs, ID_UsesRt, ID_UsesHiLo, EX_RfWr, EX_IsLoad} = '0;
      {EX_BranchTaken, EX_MduStart, EX_MduIsDiv, MEM_DmReq, DmAck} = '0;
   endtask

   // inputs are driven 1 time unit after the edge, outputs sampled 1 unit later
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mdu_seq(input logic div, input int n);
      cyc();
      clr();
      EX_MduStart = 1'b1; EX_MduIsDiv = div; ID_UsesHiLo = 1'b1;
      #1;
      chk("mdu_start_stall", outs, STAL);
      chk("mdu_start_busy", {7'd0, MduBusy}, 8'd0);
      cyc();
      EX_MduStart = 1'b0;
      for (int i = 1; i <= n; i++) begin
         #1;
         chk($sformatf("mdu_busy_%0d", i), {6'd0, MduBusy, MduDone}, {6'd0, 1'b1, i == n});
         chk($sformatf("mdu_hold_%0d", i), outs, STAL);
         cyc();
      end
      #1;
      chk("mdu_end_busy", {7'd0, MduBusy}, 8'd0);
      chk("mdu_end_adv", outs, NORM);
   endtask

   initial begin
      vec_t tbl[14];
      //            rs  rt  rw  urs urt uhl rfwr ld br dmreq ack exp
      tbl[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, NORM};
      tbl[1]  = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 1, 0, 0, 0, STAL};
      tbl[2]  = '{5'd2, 5'd5, 5'd5, 1, 1, 0, 1, 1, 0, 0, 0, STAL};
      tbl[3]  = '{5'd0, 5'd2, 5'd0, 1, 1, 0, 1, 1, 0, 0, 0, NORM};
      tbl[4]  = '{5'd5, 5'd2, 5'd5, 0, 1, 0, 1, 1, 0, 0, 0, NORM};
      tbl[5]  = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 0, 0, 0, 0, NORM};
      tbl[6]  = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 0, 1, 0, 0, 0, NORM};
      tbl[7]  = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 1, 1, 0, 0, BRAN};
      tbl[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, BRAN};
      tbl[9]  = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 1, 0, 1, 1, STAL};
      tbl[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ};
      tbl[11] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, NORM};
      tbl[12] = '{5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0, 0, NORM};
      tbl[13] = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 1, 0, 1, 0, FRZ};

      clr();
      rst_n = 1'b0;
      cyc();
      cyc();
      chk("reset_outs", outs, RST);
      chk("reset_status", {5'd0, MduBusy, MduDone, DmErr}, 8'd0);
      rst_n = 1'b1;
      #1;
      chk("post_reset", outs, NORM);

      foreach (tbl[i]) begin
         cyc();
         ID_Rs = tbl[i].rs; ID_Rt = tbl[i].rt; EX_Rw = tbl[i].rw;
         ID_UsesRs = tbl[i].urs; ID_UsesRt = tbl[i].urt; ID_UsesHiLo = tbl[i].uhl;
         EX_RfWr = tbl[i].rfwr; EX_IsLoad = tbl[i].ld; EX_BranchTaken = tbl[i].br;
         MEM_DmReq = tbl[i].dmreq; DmAck = tbl[i].ack;
         EX_MduStart = 1'b0; EX_MduIsDiv = 1'b0;
         #1;
         chk($sformatf("vec_%0d", i), outs, tbl[i].exp);
      end
      cyc();
      clr();
      #1;
      chk("after_vec_norm", outs, NORM);

      mdu_seq(1'b1, 32);
      mdu_seq(1'b0, 4);

      // 3-cycle memory wait with a branch and an MDU start pending
      for (int i = 1; i <= 3; i++) begin
         cyc();
         clr();
         MEM_DmReq = 1'b1; EX_BranchTaken = 1'b1; EX_MduStart = 1'b1;
         #1;
         chk($sformatf("dmwait_%0d", i), outs, FRZ);
         chk($sformatf("dmwait_busy_%0d", i), {7'd0, MduBusy}, 8'd0);
      end
      cyc();
      DmAck = 1'b1;
      #1;
      chk("dmwait_branch_after", outs, BRAN);
      for (int i = 1; i <= 6; i++) begin
         cyc();
         clr();
         #1;
         chk($sformatf("one_op_%0d", i), {6'd0, MduBusy, MduDone}, {6'd0, i <= 4, i == 4});
      end

      // watchdog: ack never arrives
      for (int i = 1; i <= 16; i++) begin
         cyc();
         MEM_DmReq = 1'b1;
         #1;
         chk($sformatf("wd_freeze_%0d", i), outs, FRZ);
         chk($sformatf("wd_err_%0d", i), {7'd0, DmErr}, 8'd0);
      end
      cyc();
      #1;
      chk("wd_release", outs, NORM);
      chk("wd_err_release", {7'd0, DmErr}, 8'd0);
      cyc();
      #1;
      chk("wd_err_set", {7'd0, DmErr}, 8'd1);
      chk("wd_refreeze", outs, FRZ);
      cyc();
      clr();
      #1;
      chk("wd_err_sticky", {7'd0, DmErr}, 8'd1);
      chk("wd_norm", outs, NORM);

      // reset in the middle of a divide
      cyc();
      EX_MduStart = 1'b1; EX_MduIsDiv = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         clr();
      end
      #1;
      chk("mid_div_busy", {7'd0, MduBusy}, 8'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_div_rst_outs", outs, RST);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("after_rst_status", {5'd0, MduBusy, MduDone, DmErr}, 8'd0);
      chk("after_rst_outs", outs, NORM);
      cyc();
      #1;
      chk("after_rst_idle", {7'd0, MduBusy}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
